conv_int_to_bf16: RTL and testbench
===================================

# conv_int_to_bf16

Registered converter from a signed two's-complement fixed-width integer to a bfloat16 (BF16) value, used in the conversion stage of the MX datapath. Every cycle it samples one integer, rounds it to the nearest BF16 (ties to even), and presents the result one clock later. The block has no handshake: it is a free-running, one-stage pipeline with a synchronous active-high reset.

## Interface
- `bit_width`, default 21: width of the integer input. Legal range is 2..64.
- `i_clk`  in  1: clock, rising-edge active.
- `i_rst`  in  1: reset, synchronous and active-high.
- `i_fi_num`  in  `bit_width`: signed two's-complement integer to convert.
- `o_bf16`  out  16: BF16 result, registered. Bit layout is {sign[15], exp[14:7], mantissa[6:0]}, with exponent bias 127.

## Operation
- Sign: `sign = i_fi_num[bit_width-1]`.
- Magnitude:
  - `mag = sign ? -i_fi_num : i_fi_num`, computed as an unsigned `bit_width`-bit value.
  - The most negative input, -2^(bit_width-1), gives `mag` = 2^(bit_width-1). This is exact in unsigned form and needs no saturation.
- Zero:
  - If `mag` = 0, the output is 0x0000 (positive zero).
  - There is no negative zero, and no NaN, Inf or subnormal is ever produced.
- Normalise:
  - `p` is the index of the leading one of `mag` (0..bit_width-1).
  - Unrounded exponent is `127 + p`.
  - The fraction field is the `p` bits below the leading one, left-aligned.
- Truncation:
  - The 7 most significant fraction bits form `mant`.
  - The next bit is `guard`.
  - `sticky` is the OR of all remaining lower bits.
  - If `p` ≤ 7, the fraction is zero-padded and the result is exact (guard = sticky = 0).
- Rounding (round to nearest, ties to even):
  - Increment when `guard & (sticky | mant[0])`.
  - If the increment overflows `mant` (0x7F + 1), set `mant` = 0 and exponent = `128 + p`.
- Range: exponent ≤ 127 + bit_width ≤ 191, so no overflow handling is needed within the legal `bit_width`.
- Result is `{sign, exp[7:0], mant[6:0]}`.
- Input bits are treated purely as two's complement. Width extension or truncation is the caller's responsibility.

## Timing
- Latency is exactly 1 cycle. `i_fi_num` sampled at rising edge N appears on `o_bf16` after edge N, and is valid through edge N+1.
- Throughput is one conversion per cycle, with no stalls and no internal state beyond the output register.
- Reset:
  - If `i_rst` = 1 at a rising edge, `o_bf16` becomes 0x0000 after that edge, and the input sampled at that edge is discarded.
  - Reset asserted mid-stream has the same effect. The first valid result appears one cycle after the first edge with `i_rst` = 0.
- All conversion logic is combinational between the input and the output register. It must close timing in one cycle at `bit_width` = 21.
- No X may propagate from the output register after reset, including when the input is all ones or all zeros.

## Test plan
- Reset, then basic values with `bit_width` = 21:
  - assert `i_rst` with arbitrary input -> `o_bf16` = 0x0000;
  - after release, 0 -> 0x0000;
  - 1 -> 0x3F80;
  - -1 -> 0xBF80 (each one cycle later).
- Exact values and ties (RNE):
  - 255 -> 0x437F (exact);
  - 257 -> 0x4380 (tie, rounds down to even);
  - 259 -> 0x4382 (tie, rounds up to even).
- Rounding carry into the exponent:
  - 511 -> 0x4400;
  - 1048575 (2^20-1) -> 0x4980.
- Extremes:
  - -1048576 (most negative) -> 0xC980;
  - -257 -> 0xC380.
- Exhaustive sweep over all 2^`bit_width` inputs, one per cycle. Compare the 1-cycle-delayed output against a software model (integer -> float -> BF16 with RNE), requiring bit-exact match and no X. Repeat at `bit_width` = 8 and 16.
- Reset mid-stream: pulse `i_rst` for one cycle during the sweep -> output is 0x0000 for exactly that cycle, and correct results resume on the next cycle.

Source files
------------

// File: rtl/conv_int_to_bf16.sv
// Registered signed-integer to bfloat16 converter, round-to-nearest-even.
// One-stage pipeline: all conversion logic sits in front of the output register.
module conv_int_to_bf16 #(
  parameter int bit_width = 21
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [bit_width-1:0] i_fi_num,
  output logic [15:0]          o_bf16
);

  localparam int LW = $clog2(bit_width);
  localparam int EW = bit_width + 8;
  localparam logic [LW-1:0] TOP_IDX = LW'(bit_width - 1);

  logic                 sign_s;
  logic [bit_width-1:0] mag_s;
  logic [LW-1:0]        lead_s;
  logic [LW-1:0]        shift_s;
  logic [EW-1:0]        ext_s;
  logic [6:0]           mant_s;
  logic                 guard_s;
  logic                 sticky_s;
  logic                 inc_s;
  logic [7:0]           mant_sum_s;
  logic [7:0]           exp_s;
  logic [15:0]          result_s;

  // Index of the most significant set bit; 0 when the value is zero.
  function automatic logic [LW-1:0] lead_one(input logic [bit_width-1:0] v);
    logic [LW-1:0] idx;
    idx = '0;
    for (int i = 0; i < bit_width; i++) begin
      idx = v[i] ? LW'(i) : idx;
    end
    return idx;
  endfunction

  // Sign/magnitude split and normalisation so the leading one lands on ext_s[EW-1].
  always_comb begin
    sign_s  = i_fi_num[bit_width-1];
    mag_s   = sign_s ? -i_fi_num : i_fi_num;
    lead_s  = lead_one(mag_s);
    shift_s = TOP_IDX - lead_s;
    ext_s   = {mag_s, 8'd0} << shift_s;
  end

  // Fraction extraction and RNE rounding; a mantissa carry bumps the exponent.
  always_comb begin
    mant_s     = ext_s[EW-2:EW-8];
    guard_s    = ext_s[EW-9];
    sticky_s   = |ext_s[EW-10:0];
    inc_s      = guard_s & (sticky_s | mant_s[0]);
    mant_sum_s = {1'b0, mant_s} + {7'd0, inc_s};
    exp_s      = 8'd127 + 8'(lead_s) + {7'd0, mant_sum_s[7]};
    // Normalised leading bit is clear only for a zero input.
    if (ext_s[EW-1]) begin
      result_s = {sign_s, exp_s, mant_sum_s[6:0]};
    end else begin
      result_s = 16'h0000;
    end
  end

  // Output register with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_bf16 <= 16'h0000;
    end else begin
      o_bf16 <= result_s;
    end
  end

endmodule

// File: tb/tb_conv_int_to_bf16.sv
// Directed and sweep checks of conv_int_to_bf16 at widths 21, 16 and 8.
// Expected values come from hand-computed constants and a real-number based model.
module tb_conv_int_to_bf16;

  logic               clk;
  logic               rst;
  logic signed [20:0] in21;
  logic signed [15:0] in16;
  logic signed [7:0]  in8;
  logic [15:0]        out21;
  logic [15:0]        out16;
  logic [15:0]        out8;

  int compared = 0;
  int mismatched = 0;

  conv_int_to_bf16 #(.bit_width(21)) dut21 (.i_clk(clk), .i_rst(rst), .i_fi_num(in21), .o_bf16(out21));
  conv_int_to_bf16 #(.bit_width(16)) dut16 (.i_clk(clk), .i_rst(rst), .i_fi_num(in16), .o_bf16(out16));
  conv_int_to_bf16 #(.bit_width(8))  dut8  (.i_clk(clk), .i_rst(rst), .i_fi_num(in8),  .o_bf16(out8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Integer -> double -> BF16 with round-to-nearest-even.
  function automatic logic [15:0] bf16_model(input longint v);
    real        r;
    logic [63:0] b;
    logic [6:0]  m;
    logic        g;
    logic        st;
    logic [7:0]  ms;
    logic [7:0]  e;
    if (v == 64'sd0) return 16'h0000;
    r  = real'(v);
    b  = $realtobits(r);
    m  = b[51:45];
    g  = b[44];
    st = |b[43:0];
    ms = {1'b0, m} + {7'd0, (g & (st | m[0]))};
    e  = 8'(b[62:52] - 11'd896) + {7'd0, ms[7]};
    return {b[63], e, ms[6:0]};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one 21-bit value, clock it in, and check the result 1ns after the edge.
  task automatic step21(input string tag, input logic signed [20:0] v, input logic [15:0] exp);
    in21 = v;
    @(posedge clk);
    #1;
    check(tag, out21, exp);
  endtask

  initial begin
    logic [15:0] e21;
    logic [15:0] e16;
    logic [15:0] e8;
    logic        r_now;
    rst  = 1'b1;
    in21 = 21'h1FFFFF;
    in16 = 16'hFFFF;
    in8  = 8'hFF;
    @(negedge clk);
    @(posedge clk);
    #1;
    check("reset21", out21, 16'h0000);
    check("reset16", out16, 16'h0000);
    check("reset8", out8, 16'h0000);
    rst = 1'b0;

    step21("zero", 21'sd0, 16'h0000);
    step21("one", 21'sd1, 16'h3F80);
    step21("minus_one", -21'sd1, 16'hBF80);
    step21("exact_255", 21'sd255, 16'h437F);
    step21("tie_down_257", 21'sd257, 16'h4380);
    step21("tie_up_259", 21'sd259, 16'h4382);
    step21("carry_511", 21'sd511, 16'h4400);
    step21("carry_2p20m1", 21'sd1048575, 16'h4980);
    step21("most_negative", -21'sd1048576, 16'hC980);
    step21("minus_257", -21'sd257, 16'hC380);
    step21("two_p19", 21'sd524288, 16'h4900);

    // Sweep: exhaustive at widths 16 and 8, random at 21; one-cycle reset mid-stream.
    for (int i = 0; i < 65536; i++) begin
      r_now = (i == 1000);
      rst   = r_now;
      in16  = 16'(i);
      in8   = 8'(i);
      in21  = 21'($urandom);
      e16   = r_now ? 16'h0000 : bf16_model(longint'(in16));
      e8    = r_now ? 16'h0000 : bf16_model(longint'(in8));
      e21   = r_now ? 16'h0000 : bf16_model(longint'(in21));
      @(posedge clk);
      #1;
      check("sweep16", out16, e16);
      check("sweep8", out8, e8);
      check("sweep21", out21, e21);
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
